// File: rtl/ctrl_pkg.sv
// Shared definitions for the RV32I multi-cycle control FSM: state encoding,
// opcode constants, opcode classes and the datapath select codes.
package ctrl_pkg;

    // Control FSM states; the encoding is visible on the debug 'state' port
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    // Instruction classes recognised by the decoder
    typedef enum logic [3:0] {
        CLS_ILLEGAL = 4'd0,
        CLS_LUI     = 4'd1,
        CLS_AUIPC   = 4'd2,
        CLS_JAL     = 4'd3,
        CLS_JALR    = 4'd4,
        CLS_BRANCH  = 4'd5,
        CLS_LOAD    = 4'd6,
        CLS_STORE   = 4'd7,
        CLS_OPIMM   = 4'd8,
        CLS_OP      = 4'd9
    } op_class_t;

    // RV32I base opcodes (instr[6:0])
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Immediate-format selects for the sign-extension unit
    localparam logic [2:0] SEXT_I = 3'd0;
    localparam logic [2:0] SEXT_B = 3'd1;
    localparam logic [2:0] SEXT_U = 3'd2;
    localparam logic [2:0] SEXT_S = 3'd3;
    localparam logic [2:0] SEXT_J = 3'd4;

    // Next-PC source selects
    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_ALU    = 2'd2;

    // Register-file write-back source selects
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;

    // Where an instruction goes after EXEC: branches and NOPs are done,
    // memory ops need the bus, everything else writes a register.
    function automatic state_t exec_next(input op_class_t cls);
        case (cls)
            CLS_BRANCH, CLS_ILLEGAL: return ST_FETCH;
            CLS_LOAD, CLS_STORE:     return ST_MEM;
            default:                 return ST_WB;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_opdec.sv
// Combinational opcode classifier: maps instr[6:0] to an instruction class,
// a legality flag and the immediate format the sign-extension unit needs.
module ctrl_opdec
    import ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    output op_class_t  o_class,
    output logic       o_legal,
    output logic [2:0] o_sext
);

    // Classify the opcode and pick its immediate format
    always_comb begin
        o_class = CLS_ILLEGAL;
        o_sext  = SEXT_I;
        case (i_opcode)
            OPC_LUI:    begin o_class = CLS_LUI;    o_sext = SEXT_U; end
            OPC_AUIPC:  begin o_class = CLS_AUIPC;  o_sext = SEXT_U; end
            OPC_JAL:    begin o_class = CLS_JAL;    o_sext = SEXT_J; end
            OPC_JALR:   begin o_class = CLS_JALR;   o_sext = SEXT_I; end
            OPC_BRANCH: begin o_class = CLS_BRANCH; o_sext = SEXT_B; end
            OPC_LOAD:   begin o_class = CLS_LOAD;   o_sext = SEXT_I; end
            OPC_STORE:  begin o_class = CLS_STORE;  o_sext = SEXT_S; end
            OPC_OPIMM:  begin o_class = CLS_OPIMM;  o_sext = SEXT_I; end
            // R-type has no immediate; the select is a don't-care left at I
            OPC_OP:     begin o_class = CLS_OP;     o_sext = SEXT_I; end
            default:    begin o_class = CLS_ILLEGAL; o_sext = SEXT_I; end
        endcase
        o_legal = (o_class != CLS_ILLEGAL);
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
// Outputs are decoded from the state register and the latched opcode; only
// ir_we and the MEM advance look at mem_ready, and only pc_sel in EXEC looks
// at branch_taken.
// Build option MULTICYCLE_CTRL_TRAP_EN: when defined, an illegal opcode parks
// the FSM in TRAP until reset; when undefined it executes as a NOP.
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic [2:0] sext_select,
    output logic       alu_src_sel,
    output logic       rf_we,
    output logic [1:0] wb_sel,
    output logic       illegal,
    output logic [2:0] state
);

    state_t     r_state;
    logic [6:0] r_op_q;

    logic [6:0] w_op;
    op_class_t  w_class;
    logic       w_legal;
    logic [2:0] w_sext;

    // op_q is only written at the end of DECODE, so DECODE itself must
    // classify the live opcode; every later state uses the latched copy.
    assign w_op  = (r_state == ST_DECODE) ? opcode : r_op_q;
    assign state = r_state;

    ctrl_opdec u_opdec (
        .i_opcode (w_op),
        .o_class  (w_class),
        .o_legal  (w_legal),
        .o_sext   (w_sext)
    );

    // State sequencing and opcode latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
            r_op_q  <= '0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (mem_ready) r_state <= ST_DECODE;
                end
                ST_DECODE: begin
                    r_op_q <= opcode;
`ifdef MULTICYCLE_CTRL_TRAP_EN
                    r_state <= w_legal ? ST_EXEC : ST_TRAP;
`else
                    r_state <= ST_EXEC;
`endif
                end
                ST_EXEC: begin
                    r_state <= exec_next(w_class);
                end
                ST_MEM: begin
                    if (mem_ready) r_state <= (w_class == CLS_LOAD) ? ST_WB : ST_FETCH;
                end
                ST_WB: begin
                    r_state <= ST_FETCH;
                end
                ST_TRAP: begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
                    r_state <= ST_TRAP;
`else
                    r_state <= ST_FETCH;
`endif
                end
                default: begin
                    r_state <= ST_FETCH;
                end
            endcase
        end
    end

    // Datapath controls decoded from the current state and instruction class
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = PC_PLUS4;
        alu_src_sel  = 1'b0;
        rf_we        = 1'b0;
        wb_sel       = WB_ALU;
        illegal      = 1'b0;
        sext_select  = w_sext;
        case (r_state)
            ST_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
            end
            ST_DECODE: begin
                illegal = ~w_legal;
            end
            ST_EXEC: begin
                pc_we       = 1'b1;
                alu_src_sel = ~((w_class == CLS_OP) || (w_class == CLS_BRANCH));
                case (w_class)
                    CLS_JAL:    pc_sel = PC_BRANCH;
                    CLS_BRANCH: pc_sel = branch_taken ? PC_BRANCH : PC_PLUS4;
                    CLS_JALR:   pc_sel = PC_ALU;
                    default:    pc_sel = PC_PLUS4;
                endcase
            end
            ST_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (w_class == CLS_STORE);
            end
            ST_WB: begin
                rf_we = 1'b1;
                case (w_class)
                    CLS_LOAD:          wb_sel = WB_MEM;
                    CLS_JAL, CLS_JALR: wb_sel = WB_PC4;
                    CLS_LUI:           wb_sel = WB_IMM;
                    default:           wb_sel = WB_ALU;
                endcase
            end
            ST_TRAP: begin
                illegal = 1'b1;
            end
            default: begin
                illegal = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: a table of directed instructions,
// hand-written reset/illegal sequences and a randomized instruction stream,
// all compared cycle by cycle against a phase-list reference model.
module tb_multicycle_ctrl;
    import ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = '0;
    logic       branch_taken = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, mem_addr_sel, ir_we, pc_we, alu_src_sel, rf_we, illegal;
    logic [1:0] pc_sel, wb_sel;
    logic [2:0] sext_select, state;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .sext_select(sext_select), .alu_src_sel(alu_src_sel), .rf_we(rf_we),
        .wb_sel(wb_sel), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [14:0] obs;
    assign obs = {state, mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel,
                  alu_src_sel, rf_we, wb_sel, illegal};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: instruction classes and pipeline phases
    localparam int C_ILL = 0, C_LUI = 1, C_AUIPC = 2, C_JAL = 3, C_JALR = 4;
    localparam int C_BR = 5, C_LOAD = 6, C_STORE = 7, C_OPIMM = 8, C_OP = 9;
    localparam int PH_F = 0, PH_D = 1, PH_E = 2, PH_M = 3, PH_W = 4;

    function automatic int tb_class(input logic [6:0] op);
        case (op)
            7'b0110111: return C_LUI;
            7'b0010111: return C_AUIPC;
            7'b1101111: return C_JAL;
            7'b1100111: return C_JALR;
            7'b1100011: return C_BR;
            7'b0000011: return C_LOAD;
            7'b0100011: return C_STORE;
            7'b0010011: return C_OPIMM;
            7'b0110011: return C_OP;
            default:    return C_ILL;
        endcase
    endfunction

    function automatic int model_sext(input int cls);
        if (cls == C_STORE) return 3;
        if (cls == C_BR) return 1;
        if (cls == C_LUI || cls == C_AUIPC) return 2;
        if (cls == C_JAL) return 4;
        return 0;
    endfunction

    // Expected {state, req, we, asel, ir_we, pc_we, pc_sel, alu_src, rf_we, wb_sel, illegal}
    function automatic logic [14:0] model_out(input int ph, input int cls, input bit last, input bit taken);
        logic [2:0] st;
        logic req, we, asel, irwe, pcwe, alu, rfwe, ill;
        logic [1:0] pcs, wbs;
        st = ST_FETCH; req = 0; we = 0; asel = 0; irwe = 0; pcwe = 0;
        alu = 0; rfwe = 0; ill = 0; pcs = 0; wbs = 0;
        case (ph)
            PH_F: begin st = ST_FETCH; req = 1; irwe = last; end
            PH_D: begin st = ST_DECODE; ill = (cls == C_ILL); end
            PH_E: begin
                st = ST_EXEC; pcwe = 1;
                alu = !(cls == C_OP || cls == C_BR);
                if (cls == C_JAL || (cls == C_BR && taken)) pcs = 1;
                else if (cls == C_JALR) pcs = 2;
            end
            PH_M: begin st = ST_MEM; req = 1; asel = 1; we = (cls == C_STORE); end
            default: begin
                st = ST_WB; rfwe = 1;
                if (cls == C_LOAD) wbs = 1;
                else if (cls == C_JAL || cls == C_JALR) wbs = 2;
                else if (cls == C_LUI) wbs = 3;
            end
        endcase
        return {st, req, we, asel, irwe, pcwe, pcs, alu, rfwe, wbs, ill};
    endfunction

    // Run one instruction starting at a negedge with the DUT in FETCH
    task automatic run_instr(input logic [6:0] op, input bit taken, input int fw, input int mw,
                             output int cycles, output int rf_cnt, output int pc_cnt,
                             output int sext_e, output int pcsel_e, output int wbsel_w,
                             output bit memwe_seen);
        int ph[$];
        bit lst[$];
        int cls;
        int k;
        cls = tb_class(op);
        for (int i = 0; i <= fw; i++) begin ph.push_back(PH_F); lst.push_back(i == fw); end
        ph.push_back(PH_D); lst.push_back(1'b1);
        ph.push_back(PH_E); lst.push_back(1'b1);
        if (cls == C_LOAD || cls == C_STORE)
            for (int i = 0; i <= mw; i++) begin ph.push_back(PH_M); lst.push_back(i == mw); end
        if (cls != C_BR && cls != C_ILL && cls != C_STORE) begin ph.push_back(PH_W); lst.push_back(1'b1); end
        rf_cnt = 0; pc_cnt = 0; sext_e = -1; pcsel_e = -1; wbsel_w = 0; memwe_seen = 0;
        k = 0;
        while (1) begin
            if (k > fw && state == ST_FETCH) break;
            if (k >= 40) begin
                checks++; errors++;
                $display("FAIL timeout op=%07b: still in state %0d after 40 cycles", op, state);
                break;
            end
            if (k < ph.size()) begin
                opcode       = (ph[k] == PH_F) ? 7'($urandom) : op;
                branch_taken = (ph[k] == PH_E) ? taken : 1'($urandom);
                mem_ready    = (ph[k] == PH_F || ph[k] == PH_M) ? lst[k] : 1'($urandom);
                #1;
                check($sformatf("op%07b cyc%0d outputs", op, k), 32'(obs),
                      32'(model_out(ph[k], cls, lst[k], taken)));
                if (ph[k] >= PH_E)
                    check($sformatf("op%07b cyc%0d sext", op, k), 32'(sext_select), model_sext(cls));
            end else begin
                opcode = op; mem_ready = 1'b0;
                #1;
                check($sformatf("op%07b cyc%0d overrun state", op, k), 32'(state), 32'(ST_FETCH));
            end
            if (rf_we) begin rf_cnt++; wbsel_w = int'(wb_sel); end
            if (pc_we) pc_cnt++;
            if (state == ST_EXEC) begin sext_e = int'(sext_select); pcsel_e = int'(pc_sel); end
            if (mem_req && mem_we) memwe_seen = 1'b1;
            @(negedge clk);
            k++;
        end
        cycles = k;
    endtask

    typedef struct {
        logic [6:0] op;
        bit         taken;
        int         fw, mw, cyc, sext, pcsel, wbsel, rf;
        bit         memwe;
    } vec_t;

    vec_t tbl[10];
    logic [6:0] legal_ops[9];

    initial begin
        int cyc, rf, pcc, se, ps, wbv;
        bit mwe;

        tbl[0] = '{7'b0010011, 0, 0, 0, 4, 0, 0, 0, 1, 0};  // OP-IMM
        tbl[1] = '{7'b0000011, 0, 0, 2, 7, 0, 0, 1, 1, 0};  // LOAD, 2 wait
        tbl[2] = '{7'b1100011, 1, 0, 0, 3, 1, 1, 0, 0, 0};  // BRANCH taken
        tbl[3] = '{7'b1100011, 0, 0, 0, 3, 1, 0, 0, 0, 0};  // BRANCH not taken
        tbl[4] = '{7'b1101111, 0, 0, 0, 4, 4, 1, 2, 1, 0};  // JAL
        tbl[5] = '{7'b0100011, 0, 0, 1, 5, 3, 0, 0, 0, 1};  // STORE, 1 wait
        tbl[6] = '{7'b1100111, 0, 0, 0, 4, 0, 2, 2, 1, 0};  // JALR
        tbl[7] = '{7'b0110111, 0, 0, 0, 4, 2, 0, 3, 1, 0};  // LUI
        tbl[8] = '{7'b0010111, 1, 2, 0, 6, 2, 0, 0, 1, 0};  // AUIPC, 2 fetch wait
        tbl[9] = '{7'b0110011, 0, 0, 0, 4, 0, 0, 0, 1, 0};  // OP
        legal_ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                      7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};

        // Reset state
        rst_n = 1'b0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset outputs", 32'(obs), 32'(model_out(PH_F, C_ILL, 1'b0, 1'b0)));
        check("reset sext", 32'(sext_select), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 10; i++) begin
            run_instr(tbl[i].op, tbl[i].taken, tbl[i].fw, tbl[i].mw, cyc, rf, pcc, se, ps, wbv, mwe);
            $display("vec %0d op=%07b cycles=%0d rf_we=%0d pc_sel=%0d sext=%0d wb_sel=%0d",
                     i, tbl[i].op, cyc, rf, ps, se, wbv);
            check($sformatf("vec%0d cycles", i), cyc, tbl[i].cyc);
            check($sformatf("vec%0d rf_we pulses", i), rf, tbl[i].rf);
            check($sformatf("vec%0d pc_we pulses", i), pcc, 1);
            check($sformatf("vec%0d sext", i), se, tbl[i].sext);
            check($sformatf("vec%0d pc_sel", i), ps, tbl[i].pcsel);
            check($sformatf("vec%0d wb_sel", i), wbv, tbl[i].wbsel);
            check($sformatf("vec%0d mem_we", i), 32'(mwe), 32'(tbl[i].memwe));
        end

        // Illegal opcode handling
`ifdef MULTICYCLE_CTRL_TRAP_EN
        mem_ready = 1'b1; opcode = 7'h00;
        @(negedge clk);
        opcode = 7'b1111111; mem_ready = 1'b0;
        #1;
        check("trap decode illegal", 32'(illegal), 1);
        @(negedge clk);
        #1;
        check("trap state", 32'(state), 32'(ST_TRAP));
        check("trap strobes", 32'({mem_req, ir_we, pc_we, rf_we, mem_we}), 0);
        check("trap illegal held", 32'(illegal), 1);
        for (int i = 0; i < 5; i++) begin
            mem_ready = 1'($urandom);
            @(negedge clk);
            #1;
            check($sformatf("trap stuck %0d", i), 32'(state), 32'(ST_TRAP));
        end
        rst_n = 1'b0;
        #1;
        check("trap reset state", 32'(state), 32'(ST_FETCH));
        check("trap reset illegal", 32'(illegal), 0);
        @(negedge clk);
        rst_n = 1'b1;
        $display("trap sequence done");
`else
        run_instr(7'b1111111, 1'b1, 0, 0, cyc, rf, pcc, se, ps, wbv, mwe);
        $display("illegal op=1111111 cycles=%0d rf_we=%0d pc_sel=%0d", cyc, rf, ps);
        check("illegal cycles", cyc, 3);
        check("illegal pc_sel", ps, 0);
        check("illegal pc_we", pcc, 1);
        check("illegal rf_we", rf, 0);
`endif

        // Reset in the middle of a LOAD's MEM phase
        mem_ready = 1'b1; opcode = 7'h00;
        @(negedge clk);
        opcode = 7'b0000011; mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("midmem state before reset", 32'(state), 32'(ST_MEM));
        #1;
        rst_n = 1'b0;
        #1;
        check("midmem state in reset", 32'(state), 32'(ST_FETCH));
        check("midmem rf_we in reset", 32'(rf_we), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midmem after release", 32'({state, mem_req, mem_addr_sel}), 32'({3'(ST_FETCH), 1'b1, 1'b0}));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("midmem idle %0d", i), 32'({state, rf_we, mem_req}), 32'({3'(ST_FETCH), 1'b0, 1'b1}));
        end
        @(negedge clk);
        $display("reset-in-MEM sequence done");

        // Randomized instruction stream
        for (int n = 0; n < 40; n++) begin
            logic [6:0] op;
            bit t;
            int fw, mw, c, exp_cyc;
            op = legal_ops[$urandom_range(0, 8)];
`ifndef MULTICYCLE_CTRL_TRAP_EN
            if ($urandom_range(0, 4) == 0)
                do op = 7'($urandom); while (tb_class(op) != C_ILL);
`endif
            t = 1'($urandom);
            fw = $urandom_range(0, 2);
            mw = $urandom_range(0, 2);
            c = tb_class(op);
            exp_cyc = fw + 1 + 2;
            if (c == C_LOAD || c == C_STORE) exp_cyc += mw + 1;
            if (c != C_BR && c != C_ILL && c != C_STORE) exp_cyc += 1;
            run_instr(op, t, fw, mw, cyc, rf, pcc, se, ps, wbv, mwe);
            $display("rnd %0d op=%07b taken=%0d fw=%0d mw=%0d cycles=%0d rf_we=%0d", n, op, t, fw, mw, cyc, rf);
            check($sformatf("rnd%0d cycles", n), cyc, exp_cyc);
            check($sformatf("rnd%0d rf_we pulses", n), rf,
                  (c != C_BR && c != C_ILL && c != C_STORE) ? 1 : 0);
            check($sformatf("rnd%0d pc_we pulses", n), pcc, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control FSM for the RV32I core: sequences one instruction at a time through fetch, decode, execute, memory and writeback, and drives every datapath select and write enable. It consumes the 7-bit opcode from the instruction register and generates the immediate-format select for the sign-extension unit, along with PC, register-file and memory controls. It sits between the instruction register/ALU compare flag and the shared single-port memory interface.

## Interface
- RESET_STATE, FETCH: state entered on reset
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  instr[6:0] from instruction register; stable from DECODE until next FETCH
- branch_taken  in  1  ALU compare result; sampled in EXEC only
- mem_ready  in  1  memory accepts/completes the current request this cycle
- mem_req  out  1  memory request; held until mem_ready
- mem_we  out  1  store request (qualifies mem_req)
- mem_addr_sel  out  1  0 = PC, 1 = ALU result
- ir_we  out  1  load IR and old_pc on fetch completion
- pc_we  out  1  PC update strobe
- pc_sel  out  2  0 = pc+4, 1 = old_pc+imm, 2 = ALU result (JALR, bit 0 cleared by datapath)
- sext_select  out  3  0 = I, 1 = B, 2 = U, 3 = S, 4 = J
- alu_src_sel  out  1  0 = rs2, 1 = immediate
- rf_we  out  1  register-file write strobe
- wb_sel  out  2  0 = ALU, 1 = memory data, 2 = old_pc+4, 3 = immediate
- illegal  out  1  unrecognised opcode seen in DECODE
- state  out  3  current state, for debug

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- FETCH: mem_req=1, mem_addr_sel=0, mem_we=0. When mem_ready is high: ir_we=1, go to DECODE. Otherwise stay in FETCH.
- DECODE: latch opcode into op_q and classify. Legal classes are LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011 and OP 0110011. Legal opcodes go to EXEC. Illegal opcodes set illegal=1 and go to TRAP (see Configuration).
- sext_select comes from op_q:
  - I: LOAD, OP-IMM, JALR
  - S: STORE
  - B: BRANCH
  - U: LUI, AUIPC
  - J: JAL
  - OP: sext_select=0, ignored by the datapath
- EXEC: pc_we=1 for every class. alu_src_sel=0 for OP and BRANCH, 1 otherwise. pc_sel is:
  - 1 for JAL
  - 1 for BRANCH when branch_taken=1
  - 2 for JALR
  - 0 otherwise
- EXEC next state: BRANCH goes to FETCH, LOAD/STORE go to MEM, all others go to WB.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=1 for STORE. On mem_ready, LOAD goes to WB and STORE goes to FETCH.
- WB: rf_we=1 for exactly one cycle, then go to FETCH. wb_sel is 1 for LOAD, 2 for JAL/JALR, 3 for LUI, 0 for the rest (AUIPC uses ALU old_pc+imm).
- Outputs are decoded from the state register and op_q only (Moore). The exceptions are ir_we and the MEM→WB/FETCH advance, which are qualified by mem_ready.

## Timing
- Reset (async assert, sync deassert in the datapath): state=FETCH, op_q=0, illegal=0. After reset, mem_req=1 and mem_addr_sel=0; all other outputs are 0.
- Handshake: a transfer occurs on the cycle where mem_req && mem_ready. mem_req never drops before that cycle. mem_ready while mem_req=0 is ignored.
- Minimum cycles with zero-wait memory: BRANCH 3; OP, OP-IMM, LUI, AUIPC, JAL, JALR and STORE 4; LOAD 5. Each wait cycle adds one.
- pc_we is exactly one pulse per instruction. rf_we is at most one pulse per instruction and never asserted for BRANCH or STORE.
- Reset during MEM or WB aborts the instruction with no rf_we. The next cycle after deassertion is FETCH.

## Configuration
- MULTICYCLE_CTRL_TRAP_EN defined: an illegal opcode enters TRAP. TRAP drives all strobes to 0, holds illegal=1, and stays there until rst_n.
- Not defined: an illegal opcode pulses illegal for one cycle in DECODE, then EXEC performs pc_we with pc_sel=0 (treated as NOP), then FETCH. The TRAP state is unreachable.

## Structure
- Shared package ctrl_pkg holds:
  - state enum
  - opcode constants
  - sext_select codes
  - pc_sel and wb_sel codes
- Sub-module ctrl_opdec: combinational opcode → {class, legal, sext_select}.

## Test plan
- OP-IMM 0010011, mem_ready always 1 → FETCH, DECODE, EXEC, WB; sext_select=0, alu_src_sel=1, rf_we in cycle 4, wb_sel=0.
- LOAD 0000011 with 2 wait cycles in MEM → mem_req held 3 cycles with mem_addr_sel=1; WB with wb_sel=1; total 7 cycles.
- BRANCH 1100011 with branch_taken=1, then again with 0 → pc_sel=1 then 0, sext_select=1, no rf_we, back in FETCH after 3 cycles.
- JAL 1101111 → sext_select=4, pc_sel=1 in EXEC, wb_sel=2 in WB; STORE 0100011 → sext_select=3, mem_we=1 in MEM, no rf_we.
- Opcode 1111111 → illegal=1. With TRAP_EN: stuck in TRAP until rst_n. Without: returns to FETCH with pc_sel=0.
- rst_n asserted mid-MEM of a LOAD → state=FETCH immediately, no rf_we, mem_req=1 after release.
